vram_arbiter: RTL and testbench

- Shares one single-port synchronous tile RAM between two users.
- The display scanout path issues read requests and has strict priority.
- The game-logic path issues write requests. These are buffered in a small FIFO and drained only inside a blanking window, so the picture never tears.
- The block sits between the VGA timing/pixel pipeline and the tile-map RAM.

---
 rtl/vram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port tile RAM sharing between display reads and
// buffered game-logic writes that only drain inside the blanking window.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   hblank, vblank        blanking flags from the VGA timing generator
//   disp_req/disp_addr    display read request (always accepted)
//   disp_valid/disp_data  read return, two cycles after disp_req
//   wr_req/wr_addr/wr_data/wr_ready  write request into the FIFO
//   mem_en/mem_we/mem_addr/mem_wdata registered RAM command
//   mem_rdata             RAM read data, valid the cycle after a read
//   fifo_count            entries buffered in the write FIFO
//   starve_cnt            saturating count of refused write cycles
module vram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int WR_POLICY  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hblank,
    input  logic                          vblank,
    input  logic                          disp_req,
    input  logic [ADDR_W-1:0]             disp_addr,
    output logic                          disp_valid,
    output logic [DATA_W-1:0]             disp_data,
    input  logic                          wr_req,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          wr_ready,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [7:0]                    starve_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {
        HOLD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    state_t  state;
    state_t  state_nxt;

    wr_ent_t fifo_mem [FIFO_DEPTH];
    wr_ent_t head;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count_nxt;

    logic win;
    logic armed;
    logic fifo_empty;
    logic push;
    logic pop;
    logic do_rd;
    logic do_wr;

    assign win = (WR_POLICY == 0) ? (hblank | vblank) : vblank;

    assign fifo_empty = (fifo_count == '0);
    assign push       = wr_req & wr_ready;
    assign pop        = do_wr;
    assign head       = fifo_mem[rptr];

    // armed is low for the first cycle after reset release so
    // no RAM command is issued in the cycle that follows it.
    always_comb begin
        do_rd = 1'b0;
        do_wr = 1'b0;
        unique case (1'b1)
            armed & disp_req: begin
                do_rd = 1'b1;
            end
            armed & ~disp_req & (state == DRAIN) & ~fifo_empty: begin
                do_wr = 1'b1;
            end
            default: begin
                do_rd = 1'b0;
                do_wr = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + 1'b1;
        end else if (pop && !push) begin
            count_nxt = fifo_count - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HOLD: begin
                if (win && !fifo_empty) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // leave when blanking ends or the last entry retires
                if (!win || (pop && count_nxt == '0)) begin
                    state_nxt = HOLD;
                end
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HOLD;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            wr_ready   <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            fifo_count <= count_nxt;
            wr_ready   <= (count_nxt != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr] <= '{addr: wr_addr, data: wr_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (wr_req && !wr_ready && starve_cnt != 8'hFF) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= do_rd | do_wr;
            mem_we <= do_wr;
            if (do_rd) begin
                mem_addr <= disp_addr;
            end else if (do_wr) begin
                mem_addr  <= head.addr;
                mem_wdata <= head.data;
            end
        end
    end

    // The RAM returns data the cycle after the read command, so the
    // strobe is the delayed read command and data passes straight through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= mem_en & ~mem_we;
        end
    end

    assign disp_data = disp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: two instances (drain policies 0 and 1)
// share stimulus; a queue-based reference model feeds a scoreboard.
module tb_vram_arbiter;

    localparam int AW    = 11;
    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int RAMSZ = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          hblank;
    logic          vblank;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [1:0]    disp_valid;
    logic [1:0]    wr_ready;
    logic [1:0]    mem_en;
    logic [1:0]    mem_we;
    logic [DW-1:0] disp_data  [2];
    logic [DW-1:0] mem_wdata  [2];
    logic [AW-1:0] mem_addr   [2];
    logic [2:0]    fifo_count [2];
    logic [7:0]    starve_cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] ram [RAMSZ];
        logic [DW-1:0] rdata = '0;

        initial begin
            for (int a = 0; a < RAMSZ; a++) ram[a] = DW'(a * 7 + 3);
        end

        always @(posedge clk) begin
            if (mem_en[g]) begin
                if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g];
                else           rdata <= ram[mem_addr[g]];
            end
        end

        vram_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .WR_POLICY(g)
        ) dut (
            .clk(clk), .reset(reset),
            .hblank(hblank), .vblank(vblank),
            .disp_req(disp_req), .disp_addr(disp_addr),
            .disp_valid(disp_valid[g]), .disp_data(disp_data[g]),
            .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
            .wr_ready(wr_ready[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(rdata),
            .fifo_count(fifo_count[g]), .starve_cnt(starve_cnt[g])
        );
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } went_t;

    typedef struct {
        int            cyc;
        bit            we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
    } dsp_t;

    typedef struct {
        int cyc;
        int cnt;
        int rdy;
        int stv;
    } st_t;

    went_t         fq   [2][$];
    acc_t          accq [2][$];
    dsp_t          dspq [2][$];
    st_t           stq  [2][$];
    logic [DW-1:0] shadow [2][RAMSZ];
    went_t         pend   [2];
    bit            pend_v [2];
    bit            drain  [2];
    bit            armed  [2];
    int            starve [2];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int wr_seen  [2] = '{0, 0};
    int dv_seen  [2] = '{0, 0};
    int acc_seen [2] = '{0, 0};
    int first_we [2] = '{-1, -1};

    task automatic chk(string name, int i, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d got %0d expected %0d",
                     name, i, cyc, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue, the RAM a shadow array, and
    // each cycle's grant is derived from the priority rules directly.
    task automatic model_step(int i);
        st_t   s;
        acc_t  a;
        dsp_t  d;
        went_t h;
        went_t e;
        int    n0;
        bit    w;
        bit    rdy;
        bit    popped;
        bit    pushed;
        if (reset) begin
            fq[i].delete();
            accq[i].delete();
            dspq[i].delete();
            drain[i]  = 1'b0;
            armed[i]  = 1'b0;
            pend_v[i] = 1'b0;
            starve[i] = 0;
            s.cyc = cyc; s.cnt = 0; s.rdy = 1; s.stv = 0;
            stq[i].push_back(s);
            return;
        end
        if (pend_v[i]) shadow[i][pend[i].a] = pend[i].d;
        pend_v[i] = 1'b0;
        n0  = fq[i].size();
        rdy = (n0 < DEPTH);
        s.cyc = cyc; s.cnt = n0; s.rdy = int'(rdy); s.stv = starve[i];
        stq[i].push_back(s);
        w = (i == 0) ? (hblank | vblank) : vblank;
        popped = 1'b0;
        if (armed[i] && disp_req) begin
            a.cyc = cyc + 1; a.we = 1'b0; a.a = disp_addr; a.d = '0;
            accq[i].push_back(a);
            d.cyc = cyc + 2; d.d = shadow[i][disp_addr];
            dspq[i].push_back(d);
        end else if (armed[i] && drain[i] && n0 > 0) begin
            h = fq[i].pop_front();
            popped = 1'b1;
            a.cyc = cyc + 1; a.we = 1'b1; a.a = h.a; a.d = h.d;
            accq[i].push_back(a);
            pend[i]   = h;
            pend_v[i] = 1'b1;
        end
        pushed = wr_req && rdy;
        if (pushed) begin
            e.a = wr_addr; e.d = wr_data;
            fq[i].push_back(e);
        end
        if (wr_req && !rdy && starve[i] < 255) starve[i]++;
        if (!drain[i]) drain[i] = w && (n0 > 0);
        else if (!w || (popped && !pushed && n0 == 1)) drain[i] = 1'b0;
        armed[i] = 1'b1;
    endtask

    task automatic drive(bit r, bit hb, bit vb, bit dq, int da,
                         bit wq, int wa, int wd);
        @(negedge clk);
        cyc++;
        reset     = r;
        hblank    = hb;
        vblank    = vb;
        disp_req  = dq;
        disp_addr = AW'(da);
        wr_req    = wq;
        wr_addr   = AW'(wa);
        wr_data   = DW'(wd);
        model_step(0);
        model_step(1);
    endtask

    task automatic idle(bit r, bit hb, bit vb);
        drive(r, hb, vb, 1'b0, 0, 1'b0, 0, 0);
    endtask

    task automatic check_inst(int i);
        st_t  s;
        acc_t a;
        dsp_t d;
        chk("status_present", i, int'(stq[i].size() > 0), 1);
        if (stq[i].size() > 0) begin
            s = stq[i].pop_front();
            chk("status_cyc", i, cyc, s.cyc);
            chk("fifo_count", i, int'(fifo_count[i]), s.cnt);
            chk("wr_ready", i, int'(wr_ready[i]), s.rdy);
            chk("starve_cnt", i, int'(starve_cnt[i]), s.stv);
        end
        if (mem_en[i]) begin
            acc_seen[i]++;
            if (mem_we[i]) begin
                wr_seen[i]++;
                if (first_we[i] < 0) first_we[i] = cyc;
            end
            chk("access_expected", i, int'(accq[i].size() > 0), 1);
            if (accq[i].size() > 0) begin
                a = accq[i].pop_front();
                chk("access_cyc", i, cyc, a.cyc);
                chk("mem_we", i, int'(mem_we[i]), int'(a.we));
                chk("mem_addr", i, int'(mem_addr[i]), int'(a.a));
                if (a.we) chk("mem_wdata", i, int'(mem_wdata[i]), int'(a.d));
            end
        end else if (accq[i].size() > 0 && accq[i][0].cyc <= cyc) begin
            a = accq[i].pop_front();
            chk("access_missing", i, int'(mem_en[i]), 1);
        end
        if (disp_valid[i]) begin
            dv_seen[i]++;
            chk("disp_expected", i, int'(dspq[i].size() > 0), 1);
            if (dspq[i].size() > 0) begin
                d = dspq[i].pop_front();
                chk("disp_cyc", i, cyc, d.cyc);
                chk("disp_data", i, int'(disp_data[i]), int'(d.d));
            end
        end else if (dspq[i].size() > 0 && dspq[i][0].cyc <= cyc) begin
            d = dspq[i].pop_front();
            chk("disp_missing", i, int'(disp_valid[i]), 1);
        end
        if (reset) begin
            chk("rst_mem_we", i, int'(mem_we[i]), 0);
            chk("rst_mem_addr", i, int'(mem_addr[i]), 0);
            chk("rst_mem_wdata", i, int'(mem_wdata[i]), 0);
            chk("rst_disp_data", i, int'(disp_data[i]), 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cyc > 0) begin
                check_inst(0);
                check_inst(1);
            end
        end
    end

    initial begin
        int base_w [2];
        int base_d [2];
        int mark;
        int hb;
        int vb;

        for (int i = 0; i < 2; i++)
            for (int a = 0; a < RAMSZ; a++) shadow[i][a] = DW'(a * 7 + 3);
        reset = 1'b1; hblank = 1'b0; vblank = 1'b0;
        disp_req = 1'b0; disp_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;

        // reset then idle: nothing touches the RAM
        repeat (3) idle(1'b1, 1'b0, 1'b0);
        repeat (10) idle(1'b0, 1'b0, 1'b0);
        #2;
        chk("t1_no_access", 0, acc_seen[0], 0);
        chk("t1_no_access", 1, acc_seen[1], 0);
        chk("t1_wr_ready", 0, int'(wr_ready[0]), 1);

        // fill outside the window, then starve for three cycles
        for (int k = 0; k < 4; k++)
            drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h10 + k, k + 1);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h14, 5);
        idle(1'b0, 1'b0, 1'b0);
        #2;
        chk("t2_count", 0, int'(fifo_count[0]), 4);
        chk("t2_ready", 0, int'(wr_ready[0]), 0);
        chk("t2_starve", 0, int'(starve_cnt[0]), 3);
        chk("t2_no_we", 0, wr_seen[0], 0);

        // hblank drains policy 0 only
        base_w = wr_seen;
        first_we = '{-1, -1};
        mark = cyc + 1;
        repeat (8) idle(1'b0, 1'b1, 1'b0);
        #2;
        chk("t3_writes", 0, wr_seen[0] - base_w[0], 4);
        chk("t3_first_we", 0, first_we[0], mark + 2);
        chk("t3_count", 0, int'(fifo_count[0]), 0);
        chk("t5_hblank_no_we", 1, wr_seen[1] - base_w[1], 0);
        chk("t5_count", 1, int'(fifo_count[1]), 4);

        // vblank drains policy 1
        idle(1'b0, 1'b0, 1'b0);
        base_w = wr_seen;
        first_we = '{-1, -1};
        mark = cyc + 1;
        repeat (8) idle(1'b0, 1'b0, 1'b1);
        #2;
        chk("t5_writes", 1, wr_seen[1] - base_w[1], 4);
        chk("t5_first_we", 1, first_we[1], mark + 2);
        chk("t5_count", 1, int'(fifo_count[1]), 0);

        // display reads outrank a pending drain
        idle(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h20, 7);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h21, 8);
        base_w = wr_seen;
        base_d = dv_seen;
        first_we = '{-1, -1};
        for (int k = 0; k < 5; k++)
            drive(1'b0, 1'b0, 1'b1, 1'b1, 'h100 + k, 1'b0, 0, 0);
        mark = cyc + 1;
        repeat (6) idle(1'b0, 1'b0, 1'b1);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("t4_reads", i, dv_seen[i] - base_d[i], 5);
            chk("t4_writes", i, wr_seen[i] - base_w[i], 2);
            chk("t4_resume", i, first_we[i], mark + 1);
        end

        // reset during a drain with a read in flight
        idle(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++)
            drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h30 + k, 9 + k);
        base_w = wr_seen;
        base_d = dv_seen;
        idle(1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 'h30, 1'b0, 0, 0);
        idle(1'b1, 1'b0, 1'b1);
        #2;
        chk("t6_rst_count", 0, int'(fifo_count[0]), 0);
        idle(1'b1, 1'b0, 1'b1);
        repeat (10) idle(1'b0, 1'b0, 1'b1);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("t6_no_valid", i, dv_seen[i] - base_d[i], 0);
            chk("t6_one_write", i, wr_seen[i] - base_w[i], 1);
        end

        // starvation counter saturates
        for (int k = 0; k < 4; k++)
            drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h40 + k, k);
        repeat (260) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 'h44, 0);
        idle(1'b0, 1'b0, 1'b0);
        #2;
        chk("t7_saturate", 0, int'(starve_cnt[0]), 255);
        chk("t7_saturate", 1, int'(starve_cnt[1]), 255);

        // randomized traffic with blanking, hazards and rare resets
        hb = 0;
        vb = 0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 11) == 0) hb = 1 - hb;
            if ($urandom_range(0, 39) == 0) vb = 1 - vb;
            drive(bit'($urandom_range(0, 599) == 0), bit'(hb), bit'(vb),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 15),
                  bit'($urandom_range(0, 1)), $urandom_range(0, 15),
                  $urandom_range(0, 15));
        end

        repeat (6) idle(1'b0, 1'b0, 1'b0);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("acc_left", i, accq[i].size(), 0);
            chk("disp_left", i, dspq[i].size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
